// File: rtl/window_img_arbiter.sv
// Round-robin image arbiter feeding one windower: grants whole images of
// 2^LOG2_IMG_SIZE bubble-free beats and tags each beat with its source.
// Define IMG_GAP_EN to force GAP_CYCLES idle cycles between images.
module window_img_arbiter #(
  parameter int NO_SRC        = 2,
  parameter int NO_CH         = 2,
  parameter int THROUGHPUT    = 1,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int GAP_CYCLES    = 2,
  localparam int GW = (NO_SRC > 1) ? $clog2(NO_SRC) : 1,
  localparam int DW = THROUGHPUT * NO_CH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NO_SRC-1:0]    req,
  input  logic [NO_SRC*DW-1:0] src_data,
  output logic [NO_SRC-1:0]    pop,
  output logic                 vld_out,
  output logic [DW-1:0]        data_out,
  output logic [GW-1:0]        grant_id,
  output logic                 img_start,
  output logic                 img_end,
  output logic                 busy
);

`ifdef IMG_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;
`endif

  state_t                   state, state_n;
  logic [GW-1:0]            grant, grant_n;
  logic [GW-1:0]            last, last_n;
  logic [LOG2_IMG_SIZE-1:0] cnt, cnt_n;
`ifdef IMG_GAP_EN
  logic [1:0]               gap_cnt, gap_n;
`endif

  logic          streaming;
  logic          arb_hit;
  logic [GW-1:0] arb_idx;
  logic          start_img;
  logic [DW-1:0] sel_data;
  int            best_d;
  int            d_i;

  assign streaming = (state == S_STREAM);
`ifdef IMG_GAP_EN
  assign busy = streaming || (state == S_GAP);
`else
  assign busy = streaming;
`endif

  // Round robin: rank each requester by its distance from last+1, so the
  // previous winner is ranked last and only wins when it is alone.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    best_d  = NO_SRC;
    d_i     = 0;
    arb_idx = '0;
    for (int i = 0; i < NO_SRC; i++) begin
      d_i = (i + NO_SRC - 1 - int'(last)) % NO_SRC;
      if (req[i] && d_i < best_d) begin
        best_d  = d_i;
        arb_idx = GW'(i);
      end
    end
    arb_hit = (best_d < NO_SRC);
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    last_n    = last;
    cnt_n     = cnt;
`ifdef IMG_GAP_EN
    gap_n     = gap_cnt;
`endif
    start_img = 1'b0;
    case (state)
      S_IDLE: start_img = arb_hit;
      S_STREAM: begin
        cnt_n = cnt + 1'b1;
        if (cnt == '1) begin
`ifdef IMG_GAP_EN
          state_n = S_GAP;
          gap_n   = '0;
`else
          start_img = arb_hit;
          if (!arb_hit) state_n = S_IDLE;
`endif
        end
      end
`ifdef IMG_GAP_EN
      S_GAP: begin
        if (gap_cnt == 2'(GAP_CYCLES - 1)) begin
          start_img = arb_hit;
          if (!arb_hit) state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (start_img) begin
      state_n = S_STREAM;
      grant_n = arb_idx;
      last_n  = arb_idx;
      cnt_n   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant   <= '0;
      last    <= GW'(NO_SRC - 1);
      cnt     <= '0;
`ifdef IMG_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      last    <= last_n;
      cnt     <= cnt_n;
`ifdef IMG_GAP_EN
      gap_cnt <= gap_n;
`endif
    end
  end

  always_comb begin
    pop      = '0;
    sel_data = '0;
    for (int i = 0; i < NO_SRC; i++) begin
      if (grant == GW'(i)) begin
        pop[i]   = streaming;
        sel_data = src_data[i*DW +: DW];
      end
    end
  end

  // Output stage: one cycle behind pop; data and tag hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out   <= 1'b0;
      data_out  <= '0;
      grant_id  <= '0;
      img_start <= 1'b0;
      img_end   <= 1'b0;
    end else begin
      vld_out   <= streaming;
      img_start <= streaming && (cnt == '0);
      img_end   <= streaming && (cnt == '1);
      if (streaming) begin
        data_out <= sel_data;
        grant_id <= grant;
      end
    end
  end

endmodule

// File: doc/window_img_arbiter.md
Name: window_img_arbiter

Overview:
- Shares one windower instance between NO_SRC image sources.
- Grants whole images round-robin. Each granted image is streamed as exactly 2^LOG2_IMG_SIZE contiguous valid beats, with no bubbles inside an image; this is the contract the windower's input requires.
- Sits between the per-source image buffers and the windower's vld_in/data_in, and tags every output beat with its source.

Parameters:
- NO_SRC, 2, number of requesting sources (2..8).
- NO_CH, 2, bits per channel sample.
- THROUGHPUT, 1, samples per beat (power of 2).
- LOG2_IMG_SIZE, 10, log2 of beats per image (N = 2^LOG2_IMG_SIZE).
- GAP_CYCLES, 2, idle cycles forced between images when IMG_GAP_EN is defined (1..3).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  NO_SRC  bit i high = source i holds one complete image ready.
- src_data  input  NO_SRC*THROUGHPUT*NO_CH  flattened show-ahead beat from each source; source i occupies slice i.
- pop  output  NO_SRC  one-hot; source i must advance to its next beat after each cycle pop[i] is high.
- vld_out  output  1  to windower vld_in.
- data_out  output  THROUGHPUT*NO_CH  to windower data_in.
- grant_id  output  $clog2(NO_SRC) (min 1)  source of the current vld_out beat.
- img_start  output  1  high on the first beat of an image.
- img_end  output  1  high on the last beat of an image.
- busy  output  1  high while in STREAM or GAP.

Behaviour:
- Reset values:
  - vld_out=0, data_out=0, pop=0, grant_id=0, img_start=0, img_end=0, busy=0.
  - state=IDLE, beat counter=0.
  - Round-robin pointer last=NO_SRC-1, so source 0 has highest priority after reset.
  - Reset mid-image aborts the image immediately: pop drops the next cycle and no img_end is issued.
- States:
  - IDLE: if req is nonzero, select the first set bit searching from last+1 with wrap. Register grant=g and last=g, counter=0, go to STREAM. Else stay in IDLE.
  - STREAM: pop[g]=1 (decoded from registered state), counter increments each cycle. At counter==N-1:
    - With IMG_GAP_EN: go to GAP.
    - Otherwise, if req is nonzero, re-arbitrate from last+1 and go to STREAM with counter=0 (zero-bubble back-to-back). The current source is eligible again only if no other source requests.
    - Otherwise go to IDLE.
  - GAP: pop=0. Count GAP_CYCLES cycles, then behave as IDLE in the same cycle: arbitrate if req is set, else go to IDLE.
- Datapath:
  - In every cycle with pop[g]=1, the slice for g of src_data is registered into data_out with vld_out=1.
  - Latency is 1 cycle from pop to vld_out.
  - grant_id, img_start and img_end are registered alongside and aligned to vld_out.
  - data_out holds its last value when vld_out=0.
- Timing: req sampled in IDLE at cycle t → pop on t+1..t+N → vld_out on t+2..t+N+1.
- req contract:
  - req is sampled only at arbitration points.
  - Deassertion of req[g] during its own STREAM is ignored; the source guarantees N beats.
  - A req pulse that drops before an arbitration point is lost.
- Counter: LOG2_IMG_SIZE bits, wraps from N-1 to 0; the wrap marks the image end.
- Simultaneous events: end of an image coincident with a new req is handled in that same cycle by the transition rules above.

Optional Feature:
- IMG_GAP_EN defined: forces GAP_CYCLES cycles with vld_out=0 between consecutive images, giving the windower its end-of-image flush cycles. busy stays high during the gap.
- IMG_GAP_EN undefined: GAP state and its counter are not built. Images are back-to-back with zero idle cycles when req allows.

Test Plan (LOG2_IMG_SIZE=3 → N=8, NO_SRC=2, THROUGHPUT=1, NO_CH=2):
- Reset, then req=01 held:
  - pop[0] high for 8 cycles starting 1 cycle after req is sampled.
  - vld_out high for 8 cycles, 1 cycle after pop; data_out equals source-0 beats 0..7.
  - img_start on beat 0, img_end on beat 7, grant_id=0.
- req=11 from reset, IMG_GAP_EN undefined: 16 contiguous vld_out cycles, grant_id 0 for 8 beats then 1 for 8 beats, no bubble; then source 0 again if req is still set.
- Same stimulus with IMG_GAP_EN defined and GAP_CYCLES=2: exactly 2 cycles of vld_out=0 between beat 7 of source 0 and beat 0 of source 1; busy stays high.
- req[1] only, dropped to 0 after 3 beats: still 8 beats output with img_end on beat 7, then IDLE and busy=0.
- rst asserted on beat 4 of an image: next cycle pop=0; the following cycle vld_out=0 and img_end never asserted; after rst is released with req=11, source 0 is granted first.
- req asserted on the exact cycle counter==7 of source 0's image (IMG_GAP_EN undefined): source 1 beat 0 follows source 0 beat 7 with no idle cycle.
